rv_alu_issue: RTL and testbench

- Issue stage that feeds the integer ALU; it is the producer end of the ALU's aluOp/srcA/srcB interface.
- Accepts decoded-fetch beats (instruction word, PC, register-file read data) over a valid/ready handshake.
- Decodes RV32I OP, OP-IMM, LUI and AUIPC into the 4-bit ALU opcode ({funct7[5], funct3}) and the two operands.
- Registers the result behind a 2-entry skid buffer so backpressure from execute never drops or reorders beats.

---
 rtl/rv_alu_issue_pkg.sv | 30 +++
 rtl/rv_alu_issue_dec.sv | 92 +++++++++
 rtl/rv_alu_issue.sv | 124 ++++++++++++
 tb/tb_rv_alu_issue.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_alu_issue_pkg.sv
// Shared constants for the ALU issue stage: RV32I major opcodes, ALU opcodes and beat field widths.
// The optional decode-fault flag is enabled with RV_ALU_ISSUE_ILLEGAL_EN.
package rv_alu_issue_pkg;

    localparam int BUS_W    = 32;
    localparam int INSTR_W  = 32;
    localparam int ALU_OP_W = 4;
    localparam int RD_IDX_W = 5;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;

    // ALU opcode is {funct7[5], funct3}, matching what the ALU decodes.
    localparam logic [ALU_OP_W-1:0] ADD  = 4'b0000;
    localparam logic [ALU_OP_W-1:0] SLL  = 4'b0001;
    localparam logic [ALU_OP_W-1:0] SLT  = 4'b0010;
    localparam logic [ALU_OP_W-1:0] SLTU = 4'b0011;
    localparam logic [ALU_OP_W-1:0] XOR  = 4'b0100;
    localparam logic [ALU_OP_W-1:0] SRL  = 4'b0101;
    localparam logic [ALU_OP_W-1:0] OR   = 4'b0110;
    localparam logic [ALU_OP_W-1:0] AND  = 4'b0111;
    localparam logic [ALU_OP_W-1:0] SUB  = 4'b1000;
    localparam logic [ALU_OP_W-1:0] SRA  = 4'b1101;

endpackage

// File: rtl/rv_alu_issue_dec.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decode into ALU opcode, operands, rd and writeback enable.
// RV_ALU_ISSUE_ILLEGAL_EN exposes the decode fault on illegal; otherwise illegal is tied low.
module rv_alu_dec
    import rv_alu_issue_pkg::*;
#(
    parameter int XLEN = BUS_W,
    parameter int RD_W = RD_IDX_W
) (
    input  logic [INSTR_W-1:0]  instr,
    input  logic [XLEN-1:0]     pc,
    input  logic [XLEN-1:0]     rs1_data,
    input  logic [XLEN-1:0]     rs2_data,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [XLEN-1:0]     src_a,
    output logic [XLEN-1:0]     src_b,
    output logic [RD_W-1:0]     rd,
    output logic                we,
    output logic                illegal
);

    logic [6:0]          opcode;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [XLEN-1:0]     imm_i;
    logic [XLEN-1:0]     imm_u;
    logic [ALU_OP_W-1:0] dec_op;
    logic [XLEN-1:0]     dec_a;
    logic [XLEN-1:0]     dec_b;
    logic                bad;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign imm_i  = XLEN'($signed(instr[31:20]));
    assign imm_u  = XLEN'($signed({instr[31:12], 12'h000}));

    always_comb begin
        dec_op = ADD;
        dec_a  = '0;
        dec_b  = '0;
        bad    = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_a = rs1_data;
                dec_b = rs2_data;
                if (funct7 == F7_BASE) begin
                    dec_op = {1'b0, funct3};
                end else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101)) begin
                    dec_op = {1'b1, funct3};
                end else begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec_a  = rs1_data;
                dec_b  = imm_i;
                dec_op = {1'b0, funct3};
                // Shift-immediates reuse imm[11:5] as funct7; only SRAI may set bit 30.
                if (funct3 == 3'b001) begin
                    bad = (funct7 != F7_BASE);
                end else if (funct3 == 3'b101) begin
                    dec_op = {instr[30], funct3};
                    bad    = !(funct7 == F7_BASE || funct7 == F7_ALT);
                end
            end
            OPC_LUI: begin
                dec_b = imm_u;
            end
            OPC_AUIPC: begin
                dec_a = pc;
                dec_b = imm_u;
            end
            default: begin
                bad = 1'b1;
            end
        endcase
    end

    // Illegal beats still issue, but as a harmless NOP.
    assign alu_op = bad ? ADD : dec_op;
    assign src_a  = bad ? '0 : dec_a;
    assign src_b  = bad ? '0 : dec_b;
    assign rd     = RD_W'(instr[11:7]);
    assign we     = !bad && (instr[11:7] != 5'd0);

`ifdef RV_ALU_ISSUE_ILLEGAL_EN
    assign illegal = bad;
`else
    assign illegal = 1'b0;
`endif

endmodule

// File: rtl/rv_alu_issue.sv
// ALU issue stage: decodes input beats and holds them in a 2-entry skid buffer (main M, skid S).
// RV_ALU_ISSUE_ILLEGAL_EN enables the out_illegal decode-fault flag.
module rv_alu_issue
    import rv_alu_issue_pkg::*;
#(
    parameter int XLEN = BUS_W,
    parameter int RD_W = RD_IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [INSTR_W-1:0]  in_instr,
    input  logic [XLEN-1:0]     in_pc,
    input  logic [XLEN-1:0]     in_rs1_data,
    input  logic [XLEN-1:0]     in_rs2_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ALU_OP_W-1:0] out_alu_op,
    output logic [XLEN-1:0]     out_src_a,
    output logic [XLEN-1:0]     out_src_b,
    output logic [RD_W-1:0]     out_rd,
    output logic                out_we,
    output logic                out_illegal
);

    typedef struct packed {
        logic [ALU_OP_W-1:0] alu_op;
        logic [XLEN-1:0]     src_a;
        logic [XLEN-1:0]     src_b;
        logic [RD_W-1:0]     rd;
        logic                we;
        logic                illegal;
    } beat_t;

    logic [ALU_OP_W-1:0] dec_alu_op;
    logic [XLEN-1:0]     dec_src_a;
    logic [XLEN-1:0]     dec_src_b;
    logic [RD_W-1:0]     dec_rd;
    logic                dec_we;
    logic                dec_illegal;
    beat_t               dec_beat;

    beat_t m_q, m_d, s_q, s_d;
    logic  m_valid_q, m_valid_d;
    logic  s_valid_q, s_valid_d;
    logic  m_consume;
    logic  accept;

    rv_alu_dec #(
        .XLEN (XLEN),
        .RD_W (RD_W)
    ) u_dec (
        .instr    (in_instr),
        .pc       (in_pc),
        .rs1_data (in_rs1_data),
        .rs2_data (in_rs2_data),
        .alu_op   (dec_alu_op),
        .src_a    (dec_src_a),
        .src_b    (dec_src_b),
        .rd       (dec_rd),
        .we       (dec_we),
        .illegal  (dec_illegal)
    );

    assign dec_beat = {dec_alu_op, dec_src_a, dec_src_b, dec_rd, dec_we, dec_illegal};

    // Handshake: a beat moves on either side only on a clk edge where valid & ready are both high.
    // in_ready depends only on the S flop, so out_ready never reaches it combinationally.
    assign in_ready  = !s_valid_q;
    assign m_consume = m_valid_q && out_ready;
    assign accept    = in_valid && !s_valid_q;

    always_comb begin
        m_d       = m_q;
        s_d       = s_q;
        m_valid_d = m_valid_q;
        s_valid_d = s_valid_q;
        if (flush) begin
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (s_valid_q) begin
            // S full means in_ready is low, so only the S-to-M transfer can happen.
            if (m_consume) begin
                m_d       = s_q;
                s_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!m_valid_q || m_consume) begin
                m_d       = dec_beat;
                m_valid_d = 1'b1;
            end else begin
                s_d       = dec_beat;
                s_valid_d = 1'b1;
            end
        end else if (m_consume) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            m_q       <= '0;
            s_q       <= '0;
            m_valid_q <= 1'b0;
            s_valid_q <= 1'b0;
        end else begin
            m_q       <= m_d;
            s_q       <= s_d;
            m_valid_q <= m_valid_d;
            s_valid_q <= s_valid_d;
        end
    end

    assign out_valid   = m_valid_q;
    assign out_alu_op  = m_q.alu_op;
    assign out_src_a   = m_q.src_a;
    assign out_src_b   = m_q.src_b;
    assign out_rd      = m_q.rd;
    assign out_we      = m_q.we;
    assign out_illegal = m_q.illegal;

endmodule

// File: tb/tb_rv_alu_issue.sv
// Scoreboard bench for rv_alu_issue: driver pushes reference-model beats, negedge monitor pops and compares.
// Honours RV_ALU_ISSUE_ILLEGAL_EN for the expected out_illegal value.
module tb_rv_alu_issue;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_rs1_data = '0;
    logic [31:0] in_rs2_data = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [3:0]  out_alu_op;
    logic [31:0] out_src_a;
    logic [31:0] out_src_b;
    logic [4:0]  out_rd;
    logic        out_we;
    logic        out_illegal;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_fail = 0;
    bit   rand_ready = 1'b0;
    bit   ready_force = 1'b0;

    rv_alu_issue dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .in_rs1_data (in_rs1_data),
        .in_rs2_data (in_rs2_data),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_alu_op  (out_alu_op),
        .out_src_a   (out_src_a),
        .out_src_b   (out_src_b),
        .out_rd      (out_rd),
        .out_we      (out_we),
        .out_illegal (out_illegal)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t        e;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [31:0] immi;
        logic [31:0] immu;
        bit          ok;
        f7   = ins[31:25];
        f3   = ins[14:12];
        immi = {{20{ins[31]}}, ins[31:20]};
        immu = ins & 32'hFFFF_F000;
        e    = '0;
        ok   = 1'b1;
        e.rd = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                e.a = r1;
                e.b = r2;
                if (f7 == 7'h00) e.op = {1'b0, f3};
                else if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) e.op = {1'b1, f3};
                else ok = 1'b0;
            end
            7'h13: begin
                e.a  = r1;
                e.b  = immi;
                e.op = {1'b0, f3};
                if (f3 == 3'd1 && f7 != 7'h00) ok = 1'b0;
                if (f3 == 3'd5) begin
                    if (f7 == 7'h20) e.op = 4'b1101;
                    else if (f7 != 7'h00) ok = 1'b0;
                end
            end
            7'h37: e.b = immu;
            7'h17: begin
                e.a = pc;
                e.b = immu;
            end
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.op = 4'd0;
            e.a  = '0;
            e.b  = '0;
        end
        e.we = ok && (e.rd != 5'd0);
`ifdef RV_ALU_ISSUE_ILLEGAL_EN
        e.ill = !ok;
`else
        e.ill = 1'b0;
`endif
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [6:0]  f7;
        r = $urandom;
        case ($urandom_range(0, 3))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            2: f7 = 7'($urandom);
            default: f7 = 7'h00;
        endcase
        case ($urandom_range(0, 9))
            0, 1, 2: begin
                r[6:0]   = 7'h33;
                r[31:25] = f7;
            end
            3, 4, 5: begin
                r[6:0] = 7'h13;
                if (r[13:12] == 2'b01) r[31:25] = f7;
            end
            6: r[6:0] = 7'h37;
            7: r[6:0] = 7'h17;
            default: ;
        endcase
        return r;
    endfunction

    // ---------------- checks ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #2;
            out_ready = rand_ready ? ($urandom_range(0, 99) < 70) : ready_force;
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [31:0] ins, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2);
        int n;
        n           = 0;
        in_valid    = 1'b1;
        in_instr    = ins;
        in_pc       = pc;
        in_rs1_data = r1;
        in_rs2_data = r2;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            n_vec++;
            n_fail++;
            $display("FAIL send_timeout: got in_ready=0 for 50 cycles required 1");
        end else begin
            exp_q.push_back(model(ins, pc, r1, r2));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        exp_t act;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                act = {out_alu_op, out_src_a, out_src_b, out_rd, out_we, out_illegal};
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_beat: got %h required no beat", act);
                end else begin
                    e = exp_q.pop_front();
                    if (act !== e) begin
                        n_fail++;
                        $display("FAIL beat: got op=%h a=%h b=%h rd=%0d we=%b ill=%b required op=%h a=%h b=%h rd=%0d we=%b ill=%b",
                                 act.op, act.a, act.b, act.rd, act.we, act.ill,
                                 e.op, e.a, e.b, e.rd, e.we, e.ill);
                    end
                end
            end
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        rst = 1'b1;
        step(3);
        rst = 1'b0;
        check("reset_state",
              128'({out_valid, in_ready, out_alu_op, out_src_a, out_src_b, out_rd, out_we, out_illegal}),
              128'({1'b0, 1'b1, 75'd0}));

        // Directed decodes with execute always ready.
        ready_force = 1'b1;
        step(1);
        send(32'h002081B3, 32'h0, 32'd5, 32'd7);
        check("add_latency_valid", 128'(out_valid), 128'(1));
        send(32'h40315093, 32'h4, 32'h8000_0000, 32'h0);
        send(32'hFFF00093, 32'h8, 32'h1234_5678, 32'h0);
        send(32'h123450B7, 32'hC, 32'hDEAD_BEEF, 32'h0);
        send(32'h12345097, 32'h100, 32'h0, 32'h0);
        send(32'h0000007F, 32'h104, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();

        // Backpressure: beats 1,2 fill M and S, beat 3 waits for release.
        ready_force = 1'b0;
        step(2);
        send(32'h00000013 | (32'd1 << 20) | (32'd1 << 7), 32'h200, 32'd10, 32'd0);
        send(32'h00000013 | (32'd2 << 20) | (32'd2 << 7), 32'h204, 32'd20, 32'd0);
        check("bp_in_ready_low", 128'(in_ready), 128'(0));
        step(1);
        check("bp_hold_valid", 128'({out_valid, in_ready}), 128'(2'b10));
        fork
            send(32'h00000013 | (32'd3 << 20) | (32'd3 << 7), 32'h208, 32'd30, 32'd0);
            begin
                step(1);
                ready_force = 1'b1;
            end
        join
        drain();

        // Flush with both entries full; the same-cycle input beat is dropped.
        ready_force = 1'b0;
        step(2);
        send(32'h002081B3, 32'h300, 32'd1, 32'd2);
        send(32'h402081B3, 32'h304, 32'd3, 32'd4);
        in_valid = 1'b1;
        in_instr = 32'h00A00093;
        flush    = 1'b1;
        exp_q.delete();
        step(1);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_state", 128'({out_valid, in_ready}), 128'(2'b01));
        ready_force = 1'b1;
        step(4);
        check("flush_nothing_left", 128'(out_valid), 128'(0));

        // Reset mid-stream.
        ready_force = 1'b0;
        step(2);
        send(32'h002081B3, 32'h400, 32'd9, 32'd9);
        send(32'h123450B7, 32'h404, 32'd9, 32'd9);
        rst = 1'b1;
        exp_q.delete();
        step(1);
        rst = 1'b0;
        check("midstream_reset",
              128'({out_valid, in_ready, out_alu_op, out_src_a, out_src_b, out_rd, out_we, out_illegal}),
              128'({1'b0, 1'b1, 75'd0}));

        // Randomized stream with random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) step(1);
            send(rand_instr(), $urandom, $urandom, $urandom);
        end
        rand_ready  = 1'b0;
        ready_force = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
